// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks an incrementing-counter stream and reports beat/error counts.
// Optional backpressure generator is compiled in with `define AXIS_SEQ_CHECKER_THROTTLE_EN.
module axis_seq_checker #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned EXPECT_COUNT = 10,
  parameter int unsigned START_VALUE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           beat_count,
  output logic [15:0]           error_count,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_expected
);

  localparam int unsigned CNT_W = 16;
  localparam logic [DATA_WIDTH-1:0] START_V   = DATA_WIDTH'(START_VALUE);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(EXPECT_COUNT);
  localparam logic [CNT_W-1:0]      CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [CNT_W-1:0]      beat_count_q, beat_count_d;
  logic [CNT_W-1:0]      error_count_q, error_count_d;
  logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;
  logic [DATA_WIDTH-1:0] first_err_exp_q, first_err_exp_d;
  logic                  accept;
  logic                  entering_run;

`ifdef AXIS_SEQ_CHECKER_THROTTLE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;
`endif

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      tready_q         <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      expected_q       <= START_V;
      beat_count_q     <= '0;
      error_count_q    <= '0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
`ifdef AXIS_SEQ_CHECKER_THROTTLE_EN
      lfsr_q           <= LFSR_SEED;
`endif
    end else begin
      state_q          <= state_d;
      tready_q         <= tready_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      expected_q       <= expected_d;
      beat_count_q     <= beat_count_d;
      error_count_q    <= error_count_d;
      first_err_data_q <= first_err_data_d;
      first_err_exp_q  <= first_err_exp_d;
`ifdef AXIS_SEQ_CHECKER_THROTTLE_EN
      lfsr_q           <= lfsr_d;
`endif
    end
  end

  // Next-state, checking and status logic
  always_comb begin
    state_d          = state_q;
    expected_d       = expected_q;
    beat_count_d     = beat_count_q;
    error_count_d    = error_count_q;
    first_err_data_d = first_err_data_q;
    first_err_exp_d  = first_err_exp_q;
    tready_d         = 1'b0;
    accept           = (state_q == ST_RUN) && s_tvalid && tready_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_RUN;
          expected_d       = START_V;
          beat_count_d     = '0;
          error_count_d    = '0;
          first_err_data_d = '0;
          first_err_exp_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          // Expected always advances so one corrupted beat costs exactly one error
          if (s_tdata != expected_q) begin
            if (error_count_q == '0) begin
              first_err_data_d = s_tdata;
              first_err_exp_d  = expected_q;
            end
            if (error_count_q != CNT_MAX) begin
              error_count_d = CNT_W'(error_count_q + 16'd1);
            end
          end
          expected_d   = DATA_WIDTH'(expected_q + DATA_WIDTH'(1));
          beat_count_d = CNT_W'(beat_count_q + 16'd1);
          if (beat_count_d == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    entering_run = (state_q != ST_RUN) && (state_d == ST_RUN);

`ifdef AXIS_SEQ_CHECKER_THROTTLE_EN
    // Fibonacci LFSR, taps 16,14,13,11
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = lfsr_q;
    if (entering_run) begin
      lfsr_d = LFSR_SEED;
    end else if (state_q == ST_RUN) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
    if (state_d == ST_RUN) begin
      tready_d = lfsr_d[0] | lfsr_d[1];
    end
`else
    if (state_d == ST_RUN) begin
      tready_d = 1'b1;
    end
`endif

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (error_count_d == '0);
  end

  assign s_tready           = tready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign beat_count         = beat_count_q;
  assign error_count        = error_count_q;
  assign first_err_data     = first_err_data_q;
  assign first_err_expected = first_err_exp_q;

endmodule
